// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_access_stage_pkg                                            |
// | Brief    : Shared types and constants for the pipeline memory-access stage |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mem_access_stage_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [1:0] c_MTR_ALU = 2'd0;
    localparam logic [1:0] c_MTR_MEM = 2'd1;
    localparam logic [1:0] c_MTR_PC4 = 2'd2;

    localparam int c_TIMEOUT_DEFAULT = 255;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_wb_reg                                                      |
// | Brief    : MEM/WB pipeline register, loads the stage result or a bubble    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_bubble,
    input  logic [31:0] i_read_data,
    input  logic [31:0] i_alu_res,
    input  logic [4:0]  i_rd,
    input  logic [1:0]  i_mem_to_reg,
    input  logic        i_reg_write,
    output logic [31:0] o_read_data,
    output logic [31:0] o_alu_res,
    output logic [4:0]  o_rd,
    output logic [1:0]  o_mem_to_reg,
    output logic        o_reg_write
);

    logic [31:0] r_read_data;
    logic [31:0] r_alu_res;
    logic [4:0]  r_rd;
    logic [1:0]  r_mem_to_reg;
    logic        r_reg_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || i_bubble) begin
            r_read_data  <= '0;
            r_alu_res    <= '0;
            r_rd         <= '0;
            r_mem_to_reg <= '0;
            r_reg_write  <= 1'b0;
        end else begin
            r_read_data  <= i_read_data;
            r_alu_res    <= i_alu_res;
            r_rd         <= i_rd;
            r_mem_to_reg <= i_mem_to_reg;
            r_reg_write  <= i_reg_write;
        end
    end

    assign o_read_data  = r_read_data;
    assign o_alu_res    = r_alu_res;
    assign o_rd         = r_rd;
    assign o_mem_to_reg = r_mem_to_reg;
    assign o_reg_write  = r_reg_write;

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_access_stage                                                |
// | Brief    : Pipeline MEM stage: memory handshake FSM, stall, MEM/WB feed.   |
// |            Define MEM_TIMEOUT_EN to enable the mem_ready watchdog.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_res_input,
    input  logic [31:0] WriteData_input,
    input  logic [4:0]  rd_input,
    input  logic [1:0]  MemToReg_input,
    input  logic        RegWrite_input,
    input  logic        MemRead_input,
    input  logic        MemWrite_input,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic [31:0] ReadData_output,
    output logic [31:0] ALU_res_output,
    output logic [4:0]  rd_output,
    output logic [1:0]  MemToReg_output,
    output logic        RegWrite_output,
    output logic        err_misalign,
    output logic        err_timeout
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_memop;
    logic        w_aligned;
    logic        w_done;
    logic        w_abort;
    logic        r_err_misalign;
    logic [31:0] w_read_data;

    assign w_memop   = MemRead_input | MemWrite_input;
    assign w_aligned = is_aligned(ALU_res_input);

    // rst gates the request path so an in-flight access vanishes the moment reset is raised
    assign mem_req   = !rst && (((r_state == IDLE) && w_memop && w_aligned) || (r_state == WAIT));
    assign mem_we    = !rst && MemWrite_input;
    assign mem_addr  = rst ? 32'd0 : ALU_res_input;
    assign mem_wdata = rst ? 32'd0 : WriteData_input;

    assign w_done    = mem_req && mem_ready;
    assign stall     = !rst && w_memop && w_aligned && !w_done && !w_abort;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (mem_req && !mem_ready) w_state_nxt = WAIT;
            WAIT:    if (w_done || w_abort)     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

`ifdef MEM_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_err_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          r_wait_cnt <= '0;
        else if ((r_state == IDLE) && (w_state_nxt == WAIT)) r_wait_cnt <= '0;
        else if (r_state == WAIT)                         r_wait_cnt <= r_wait_cnt + 1'b1;
    end

    // The issue cycle plus TIMEOUT_CYCLES-1 WAIT cycles stall; the next WAIT cycle aborts
    assign w_abort = (r_state == WAIT) && !mem_ready
                     && (r_wait_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_err_timeout <= 1'b0;
        else if (w_abort) r_err_timeout <= 1'b1;
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_abort     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         r_err_misalign <= 1'b0;
        else if (w_memop && !w_aligned)  r_err_misalign <= 1'b1;
    end

    assign err_misalign = r_err_misalign;

    // A read-and-write op is a write, so only a pure read returns data
    assign w_read_data = (w_done && !MemWrite_input) ? mem_rdata : 32'd0;

    mem_wb_reg u_mem_wb_reg (
        .clk          (clk),
        .rst          (rst),
        .i_bubble     (stall || w_abort),
        .i_read_data  (w_read_data),
        .i_alu_res    (ALU_res_input),
        .i_rd         (rd_input),
        .i_mem_to_reg (MemToReg_input),
        .i_reg_write  (RegWrite_input && (w_aligned || !w_memop)),
        .o_read_data  (ReadData_output),
        .o_alu_res    (ALU_res_output),
        .o_rd         (rd_output),
        .o_mem_to_reg (MemToReg_output),
        .o_reg_write  (RegWrite_output)
    );

endmodule
`default_nettype wire
